// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//   Elastic pipeline register between two CPU pipeline stages. It carries a
//   payload, control bits and an exception code across a valid/ready
//   handshake. A 2-entry skid buffer (output slot + skid slot) sustains one
//   transfer per cycle while in_ready stays fully registered.
//
// Ports
//   CLK          rising-edge clock
//   reset        asynchronous active-high reset; clears every register
//   flush        synchronous kill of both slots; wins over all other events
//   in_valid     upstream offers an entry
//   in_ready     stage can accept (low only while the skid slot is occupied)
//   in_data      payload in
//   in_ctrl      control bits in
//   in_exc       exception code in (0 = none)
//   out_valid    output slot holds an entry
//   out_ready    downstream accepts the output slot
//   out_data     payload of the output slot
//   out_ctrl     control bits of the output slot (0 when empty)
//   out_exc      exception code of the output slot (0 when empty)
//   exc_pending  some occupied slot carries a non-zero exception code
//   cnt_clr      synchronous clear of stall_cnt (beats increment)
//   stall_cnt    saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [EXC_W-1:0]  out_exc,
  output logic              exc_pending,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [EXC_W-1:0]  skid_exc;

  logic              out_valid_nxt, skid_valid_nxt;
  logic [DATA_W-1:0] out_data_nxt, skid_data_nxt;
  logic [CTRL_W-1:0] out_ctrl_nxt, skid_ctrl_nxt;
  logic [EXC_W-1:0]  out_exc_nxt, skid_exc_nxt;
  logic              exc_pending_nxt;
  logic [CNT_W-1:0]  stall_cnt_nxt;

  logic acc, con;

  // in_ready is the inverse of a flop, so it carries no combinational path
  // from out_ready back upstream.
  assign in_ready = ~skid_valid;
  assign acc      = in_valid & in_ready;
  assign con      = out_valid & out_ready;

  always_comb begin
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_ctrl_nxt   = out_ctrl;
    out_exc_nxt    = out_exc;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_ctrl_nxt  = skid_ctrl;
    skid_exc_nxt   = skid_exc;

    if (flush) begin
      // Data is left alone; only the fields consumers act on are cleared.
      out_valid_nxt  = 1'b0;
      out_ctrl_nxt   = '0;
      out_exc_nxt    = '0;
      skid_valid_nxt = 1'b0;
      skid_ctrl_nxt  = '0;
      skid_exc_nxt   = '0;
    end else if (!out_valid || con) begin
      if (skid_valid) begin
        // Older skid entry advances first to keep FIFO order.
        out_valid_nxt = 1'b1;
        out_data_nxt  = skid_data;
        out_ctrl_nxt  = skid_ctrl;
        out_exc_nxt   = skid_exc;
        if (acc) begin
          skid_data_nxt = in_data;
          skid_ctrl_nxt = in_ctrl;
          skid_exc_nxt  = in_exc;
        end else begin
          skid_valid_nxt = 1'b0;
          skid_ctrl_nxt  = '0;
          skid_exc_nxt   = '0;
        end
      end else if (acc) begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
        out_ctrl_nxt  = in_ctrl;
        out_exc_nxt   = in_exc;
      end else begin
        out_valid_nxt = 1'b0;
        out_ctrl_nxt  = '0;
        out_exc_nxt   = '0;
      end
    end else if (acc) begin
      // Output slot stalled: acc implies the skid slot is free.
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = in_data;
      skid_ctrl_nxt  = in_ctrl;
      skid_exc_nxt   = in_exc;
    end

    exc_pending_nxt = (out_valid_nxt & (|out_exc_nxt)) |
                      (skid_valid_nxt & (|skid_exc_nxt));

    stall_cnt_nxt = stall_cnt;
    if (cnt_clr)
      stall_cnt_nxt = '0;
    else if (out_valid && !out_ready)
      stall_cnt_nxt = sat_inc(stall_cnt);
  end

  // ---- stage boundary: input side -> output/skid registers ----
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ctrl    <= '0;
      out_exc     <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_ctrl   <= '0;
      skid_exc    <= '0;
      exc_pending <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      out_valid   <= out_valid_nxt;
      out_data    <= out_data_nxt;
      out_ctrl    <= out_ctrl_nxt;
      out_exc     <= out_exc_nxt;
      skid_valid  <= skid_valid_nxt;
      skid_data   <= skid_data_nxt;
      skid_ctrl   <= skid_ctrl_nxt;
      skid_exc    <= skid_exc_nxt;
      exc_pending <= exc_pending_nxt;
      stall_cnt   <= stall_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//   Directed bench for pipe_stage_elastic (CNT_W=4 so saturation is short).
//   A table of per-cycle vectors covers streaming, back-pressure, flush and
//   exception tracking; hand-written sequences cover counter saturation and
//   an asynchronous reset between clock edges.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  logic        CLK = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic [4:0]  in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [4:0]  out_exc;
  logic        exc_pending;
  logic        cnt_clr;
  logic [3:0]  stall_cnt;

  pipe_stage_elastic #(
    .DATA_W(32), .CTRL_W(8), .EXC_W(5), .CNT_W(4)
  ) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_exc(out_exc),
    .exc_pending(exc_pending), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        fl, iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic [4:0]  e;
    logic        ordy, clr;
    logic        eov;
    logic [31:0] ed;
    logic [7:0]  ec;
    logic [4:0]  ee;
    logic        eir, eexp;
    logic [3:0]  ecnt;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    input logic fl, input logic iv, input logic [31:0] d, input logic [7:0] c,
    input logic [4:0] e, input logic ordy, input logic clr,
    input logic eov, input logic [31:0] ed, input logic [7:0] ec,
    input logic [4:0] ee, input logic eir, input logic eexp, input logic [3:0] ecnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.e = e; v.ordy = ordy; v.clr = clr;
    v.eov = eov; v.ed = ed; v.ec = ec; v.ee = ee; v.eir = eir; v.eexp = eexp;
    v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic eov, input logic [31:0] ed,
                         input logic [7:0] ec, input logic [4:0] ee, input logic eir,
                         input logic eexp, input logic [3:0] ecnt);
    chk({tag, ".out_valid"},   32'(out_valid),   32'(eov));
    if (eov) chk({tag, ".out_data"}, out_data, ed);
    chk({tag, ".out_ctrl"},    32'(out_ctrl),    32'(ec));
    chk({tag, ".out_exc"},     32'(out_exc),     32'(ee));
    chk({tag, ".in_ready"},    32'(in_ready),    32'(eir));
    chk({tag, ".exc_pending"}, 32'(exc_pending), 32'(eexp));
    chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(ecnt));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                       input logic [7:0] c, input logic [4:0] e,
                       input logic ordy, input logic clr);
    flush = fl; in_valid = iv; in_data = d; in_ctrl = c; in_exc = e;
    out_ready = ordy; cnt_clr = clr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming 1..8 with out_ready=1: each appears one cycle after acceptance.
    for (int i = 1; i <= 8; i++)
      tbl[i-1] = mk(0, 1, 32'(i), 8'(i), 5'd0, 1, 0, 1, 32'(i), 8'(i), 5'd0, 1, 0, 4'd0);
    tbl[8]  = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);
    // Back-pressure: A held, B into skid, C refused until room frees up.
    tbl[9]  = mk(0, 1, 32'hA, 8'h11, 5'd0, 0, 0, 1, 32'hA, 8'h11, 5'd0, 1, 0, 4'd0);
    tbl[10] = mk(0, 1, 32'hB, 8'h22, 5'd0, 0, 0, 1, 32'hA, 8'h11, 5'd0, 0, 0, 4'd1);
    tbl[11] = mk(0, 1, 32'hC, 8'h33, 5'd0, 0, 0, 1, 32'hA, 8'h11, 5'd0, 0, 0, 4'd2);
    tbl[12] = mk(0, 1, 32'hC, 8'h33, 5'd0, 1, 0, 1, 32'hB, 8'h22, 5'd0, 1, 0, 4'd2);
    tbl[13] = mk(0, 1, 32'hC, 8'h33, 5'd0, 1, 0, 1, 32'hC, 8'h33, 5'd0, 1, 0, 4'd2);
    tbl[14] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd2);
    tbl[15] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 1, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);
    // Flush with both slots full (skid carries exc 3), then flush with acc+con.
    tbl[16] = mk(0, 1, 32'hD, 8'h44, 5'd0, 0, 0, 1, 32'hD, 8'h44, 5'd0, 1, 0, 4'd0);
    tbl[17] = mk(0, 1, 32'hE, 8'h55, 5'd3, 0, 0, 1, 32'hD, 8'h44, 5'd0, 0, 1, 4'd1);
    tbl[18] = mk(1, 1, 32'hF, 8'h66, 5'd0, 0, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd2);
    tbl[19] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd2);
    tbl[20] = mk(0, 1, 32'h9, 8'h77, 5'd0, 0, 0, 1, 32'h9, 8'h77, 5'd0, 1, 0, 4'd2);
    tbl[21] = mk(1, 1, 32'h7, 8'h88, 5'd1, 1, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd2);
    tbl[22] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd2);
    tbl[23] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 1, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);
    // Exception entry (code 4) queued behind a stalled clean entry.
    tbl[24] = mk(0, 1, 32'h101, 8'h01, 5'd0, 0, 0, 1, 32'h101, 8'h01, 5'd0, 1, 0, 4'd0);
    tbl[25] = mk(0, 1, 32'h102, 8'h02, 5'd4, 0, 0, 1, 32'h101, 8'h01, 5'd0, 0, 1, 4'd1);
    tbl[26] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 1, 32'h102, 8'h02, 5'd4, 1, 1, 4'd1);
    tbl[27] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd1);
    tbl[28] = mk(0, 0, 32'h0, 8'h00, 5'd0, 1, 1, 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);

    reset = 1'b1;
    drive(0, 0, 32'h0, 8'h00, 5'd0, 1, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    chk("reset.out_data", out_data, 32'h0);
    chk_all("reset", 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].e, tbl[i].ordy, tbl[i].clr);
      @(posedge CLK);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].eov, tbl[i].ed, tbl[i].ec, tbl[i].ee,
              tbl[i].eir, tbl[i].eexp, tbl[i].ecnt);
    end

    // Counter saturation: one entry stalled for 20 cycles.
    @(negedge CLK);
    drive(0, 1, 32'h5A, 8'h05, 5'd0, 0, 0);
    @(posedge CLK);
    #1;
    chk("sat.load_valid", 32'(out_valid), 32'd1);
    @(negedge CLK);
    drive(0, 0, 32'h0, 8'h00, 5'd0, 0, 0);
    repeat (20) @(posedge CLK);
    #1;
    chk("sat.cnt_20", 32'(stall_cnt), 32'd15);
    @(posedge CLK);
    #1;
    chk("sat.cnt_hold", 32'(stall_cnt), 32'd15);
    chk("sat.data_hold", out_data, 32'h5A);
    @(negedge CLK);
    cnt_clr = 1'b1;
    @(posedge CLK);
    #1;
    chk("sat.clr", 32'(stall_cnt), 32'd0);
    @(negedge CLK);
    cnt_clr = 1'b0;
    @(posedge CLK);
    #1;
    chk("sat.recount", 32'(stall_cnt), 32'd1);

    // Fill skid too, then assert reset between clock edges.
    @(negedge CLK);
    drive(0, 1, 32'h77, 8'h09, 5'd2, 0, 0);
    @(posedge CLK);
    #1;
    chk("arst.pre_in_ready", 32'(in_ready), 32'd0);
    chk("arst.pre_exc_pending", 32'(exc_pending), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_data", out_data, 32'h0);
    chk_all("arst", 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);
    @(negedge CLK);
    reset = 1'b0;
    drive(0, 0, 32'h0, 8'h00, 5'd0, 1, 0);
    @(posedge CLK);
    #1;
    chk_all("arst.after", 0, 32'h0, 8'h00, 5'd0, 1, 0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
